// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate data cache.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module cache_controller #(
  parameter int SET_BITS = 6,
  parameter int TAG_BITS = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_e;

  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     lru_q;
  logic [TAG_BITS-1:0] tag_q [2][SETS];
  logic [63:0]         data_q [2][SETS];

  logic [31:0]         la;
  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tg;
  logic                hit0, hit1, hit;
  logic                hway, victim;
  logic [63:0]         hblk;
  logic [31:0]         hword, fword;
  logic                rd_hit, fill_en;
  logic                wr_upd, miss_go;
  logic                unused_bits;

  // Lookup uses the live address in IDLE,
  // the captured one while a transaction runs.
  assign la   = (state_q == IDLE) ? mem_address : addr_q;
  assign idx  = la[SET_BITS+2:3];
  assign tg   = la[SET_BITS+TAG_BITS+2:SET_BITS+3];
  assign hit0 = valid_q[0][idx] && (tag_q[0][idx] == tg);
  assign hit1 = valid_q[1][idx] && (tag_q[1][idx] == tg);
  assign hit  = hit0 | hit1;
  assign hway = ~hit0;
  assign hblk = hit0 ? data_q[0][idx] : data_q[1][idx];
  assign hword = la[2] ? hblk[63:32] : hblk[31:0];
  assign fword = addr_q[2] ? sram_rdata[63:32]
                           : sram_rdata[31:0];
  assign victim = !valid_q[0][idx] ? 1'b0 :
                  !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign unused_bits = ^{la[1:0], la[31:SET_BITS+TAG_BITS+3]};

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = '0;
    sram_wdata   = mem_wdata;
    rd_hit       = 1'b0;
    fill_en      = 1'b0;
    wr_upd       = 1'b0;
    miss_go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d  = mem_address;
        wdata_d = mem_wdata;
        unique case (1'b1)
          mem_wr_en: state_d = WR_THRU;
          mem_rd_en: begin
            if (hit) begin
              mem_ready = 1'b1;
              mem_rdata = hword;
              rd_hit    = 1'b1;
            end else begin
              state_d = RD_MISS;
              miss_go = 1'b1;
            end
          end
          default: mem_ready = 1'b1;
        endcase
      end
      RD_MISS: begin
        sram_rd_en   = 1'b1;
        sram_address = addr_q;
        if (sram_ready) begin
          mem_ready = 1'b1;
          mem_rdata = mem_rd_en ? fword : '0;
          fill_en   = 1'b1;
          state_d   = IDLE;
        end
      end
      WR_THRU: begin
        sram_wr_en   = 1'b1;
        sram_address = addr_q;
        sram_wdata   = wdata_q;
        if (sram_ready) begin
          mem_ready = 1'b1;
          wr_upd    = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and captured request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Valid and LRU bits, changed only on hits and completions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (fill_en) begin
      valid_q[victim][idx] <= 1'b1;
      lru_q[idx]           <= ~victim;
    end else if (rd_hit || wr_upd) begin
      lru_q[idx] <= ~hway;
    end
  end

  // Tag and data storage, not reset
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim][idx]  <= tg;
      data_q[victim][idx] <= sram_rdata;
    end else if (wr_upd) begin
      if (la[2]) data_q[hway][idx][63:32] <= wdata_q;
      else       data_q[hway][idx][31:0]  <= wdata_q;
    end
  end

`ifdef CACHE_STATS_EN
  // Read hit and read miss counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit)  hit_count  <= hit_count + 32'd1;
      if (miss_go) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
